dl_tx_arbiter_gen2: RTL and testbench
=====================================

Name: dl_tx_arbiter_gen2

Overview:
- Next-generation Data Link TX arbiter. Merges three packet sources into the single stream sent to the physical layer: replay-buffer TLPs, newly sequenced TLPs from the TLP mux, and DLLPs from the DLLP creator with their CRC16.
- Adds per-packet locking, valid/ready backpressure from the PHY, Ack/Nak urgency, blocking of new TLPs during replay, and a DLLP starvation guard.
- Data width and length width are parametrised.

Parameters:
- DATA_W, 128, beat width of the TLP paths and of tx_out.
- LEN_W, 6, width of the per-beat length fields (valid DW count).
- STARVE_LIMIT, 4, number of consecutive TLP grants a pending non-urgent DLLP tolerates before it is promoted.
- STARVE_CNT_W, 3, width of the starvation counter; must satisfy STARVE_CNT_W >= clog2(STARVE_LIMIT+1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rb_data  in  DATA_W  replay-buffer beat
- rb_valid  in  1  replay beat valid
- rb_end  in  1  last beat of replay TLP
- rb_len  in  LEN_W  valid DWs in the replay beat
- rb_ready  out  1  replay beat accepted this cycle
- nt_data  in  DATA_W  new-TLP beat from the TLP mux
- nt_valid  in  1  new-TLP beat valid
- nt_end  in  1  last beat of the new TLP
- nt_len  in  LEN_W  valid DWs in the new-TLP beat
- nt_ready  out  1  new-TLP beat accepted this cycle
- dllp_data  in  32  DLLP body
- dllp_crc  in  16  DLLP CRC16
- dllp_valid  in  1  DLLP pending
- dllp_urgent  in  1  pending DLLP is an Ack/Nak
- dllp_ready  out  1  DLLP accepted this cycle
- replay_active  in  1  replay in progress; blocks new-TLP grants
- tx_ready  in  1  PHY accepts the tx_out beat
- tx_out  out  DATA_W  output beat
- tx_out_valid  out  1  output beat valid
- tx_type  out  1  1 = TLP beat, 0 = DLLP
- tx_out_end  out  1  last beat of packet
- tx_out_len  out  LEN_W  valid DWs in the output beat
- tx_src  out  2  source of the output beat: 0 = RB, 1 = NT, 2 = DLLP
- starve_event  out  1  one-cycle pulse when a DLLP is promoted
- busy  out  1  packet in flight or output occupied

Behaviour:
- Reset: state IDLE, starvation counter 0. All outputs are 0: tx_out, tx_out_valid, tx_type, tx_out_end, tx_out_len, tx_src, starve_event, busy. All readies are 0.
- out_free = !tx_out_valid | tx_ready.
- A beat transfers on valid & ready. The output register loads on that edge, so latency is 1 cycle. Packets can run back-to-back with no bubble.
- When out_free = 0: all readies are 0 and every tx_* output holds stable.
- When out_free = 1 and no source is accepted: tx_out_valid = 0 on the next cycle.
- FSM states: IDLE, LOCK_RB, LOCK_NT.
- IDLE grant is combinational in the same cycle, in this priority order:
  1. urgent DLLP
  2. promoted DLLP (counter == STARVE_LIMIT)
  3. RB
  4. NT, only if !replay_active
  5. non-urgent DLLP
- In IDLE, granting a non-end TLP beat moves the FSM to LOCK_RB or LOCK_NT. A TLP with end=1 on its first beat, or any DLLP, stays in IDLE.
- LOCK_x: only source x is granted, and urgent DLLPs wait. Return to IDLE when the end beat is accepted. If x_valid drops mid-packet, tx_out_valid drops (bubble) and the lock is held.
- replay_active rising during LOCK_NT: the NT packet completes; it is not truncated.
- DLLP beat format:
  - tx_out[DATA_W-1 -: 48] = {dllp_data, dllp_crc}; remaining bits 0.
  - tx_type = 0, tx_out_end = 1, tx_out_len = 2, tx_src = 2.
- TLP beat: data and len pass through; tx_type = 1; tx_src = 0 or 1.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, on each accepted TLP end beat while dllp_valid & !dllp_urgent.
  - Clears when a DLLP is accepted or when dllp_valid = 0.
  - starve_event pulses in the cycle a promoted DLLP is accepted.
- busy = (state != IDLE) | tx_out_valid.
- Reset asserted mid-packet: immediate return to reset values. Partial packets are dropped with no end beat emitted; upstream blocks restart.

Test Plan:
- RB 3-beat TLP (len 4,4,2) with tx_ready = 1 -> tx_out shows 3 beats one cycle after each accept; tx_src = 0; tx_out_end only on beat 3; tx_type = 1.
- Urgent DLLP 0xAABBCCDD, CRC 0x1234, raised while an NT 4-beat TLP is on beat 2 -> NT completes; DLLP follows with no bubble; tx_out[127:80] = 0xAABBCCDD1234; tx_out_len = 2.
- rb_valid and nt_valid both high with replay_active = 1 -> RB granted; nt_ready stays 0 until replay_active = 0.
- Non-urgent DLLP pending with 6 single-beat TLPs queued, STARVE_LIMIT = 4 -> 4 TLPs sent, then the DLLP with starve_event = 1 for one cycle, then the remaining TLPs.
- tx_ready held low for 3 cycles mid-packet -> tx_out holds its value; all readies are 0; no beat is lost or duplicated after release.
- rst pulsed on beat 2 of a 4-beat RB TLP -> next cycle tx_out_valid = 0, busy = 0, state IDLE; a new packet is accepted normally afterwards.

Source files
------------

// File: rtl/dl_tx_arbiter_gen2.sv
// dl_tx_arbiter_gen2 -- Data Link TX arbiter.
// Merges replay-buffer TLPs (rb_*), new TLPs (nt_*) and DLLPs (dllp_*) into
// one registered output stream (tx_*) toward the PHY, with valid/ready
// backpressure (tx_ready).
//   clk, rst          : clock, asynchronous active-high reset
//   rb_*  / nt_*      : TLP beat sources (data, valid, end, len, ready)
//   dllp_*            : DLLP body + CRC16, urgent = Ack/Nak
//   replay_active     : blocks new-TLP grants from IDLE
//   tx_*              : output beat, type (1 = TLP), end, len, source
//   starve_event      : pulse when a starved DLLP is promoted and accepted
//   busy              : packet locked or output beat occupied
module dl_tx_arbiter_gen2 #(
    parameter int DATA_W       = 128,
    parameter int LEN_W        = 6,
    parameter int STARVE_LIMIT = 4,
    parameter int STARVE_CNT_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rb_data,
    input  logic              rb_valid,
    input  logic              rb_end,
    input  logic [LEN_W-1:0]  rb_len,
    output logic              rb_ready,
    input  logic [DATA_W-1:0] nt_data,
    input  logic              nt_valid,
    input  logic              nt_end,
    input  logic [LEN_W-1:0]  nt_len,
    output logic              nt_ready,
    input  logic [31:0]       dllp_data,
    input  logic [15:0]       dllp_crc,
    input  logic              dllp_valid,
    input  logic              dllp_urgent,
    output logic              dllp_ready,
    input  logic              replay_active,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] tx_out,
    output logic              tx_out_valid,
    output logic              tx_type,
    output logic              tx_out_end,
    output logic [LEN_W-1:0]  tx_out_len,
    output logic [1:0]        tx_src,
    output logic              starve_event,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, LOCK_RB, LOCK_NT} state_t;

    state_t                  state, state_nxt;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic                    out_free;
    logic                    promoted;
    logic                    g_rb, g_nt, g_dllp, g_promote;
    logic [DATA_W-1:0]       dllp_beat;

    // Output slot can take a new beat if empty or draining this cycle.
    assign out_free = !tx_out_valid || tx_ready;
    assign promoted = dllp_valid && !dllp_urgent &&
                      (starve_cnt == STARVE_CNT_W'(STARVE_LIMIT));

    always_comb begin
        dllp_beat = '0;
        dllp_beat[DATA_W-1 -: 48] = {dllp_data, dllp_crc};
    end

    // Grant and next state. Grants are gated by rst so readies read 0
    // while reset is held.
    always_comb begin
        g_rb      = 1'b0;
        g_nt      = 1'b0;
        g_dllp    = 1'b0;
        g_promote = 1'b0;
        state_nxt = state;
        if (!rst && out_free) begin
            case (state)
                IDLE: begin
                    if (dllp_valid && dllp_urgent) begin
                        g_dllp = 1'b1;
                    end else if (promoted) begin
                        g_dllp    = 1'b1;
                        g_promote = 1'b1;
                    end else if (rb_valid) begin
                        g_rb = 1'b1;
                        if (!rb_end) state_nxt = LOCK_RB;
                    end else if (nt_valid && !replay_active) begin
                        g_nt = 1'b1;
                        if (!nt_end) state_nxt = LOCK_NT;
                    end else if (dllp_valid) begin
                        g_dllp = 1'b1;
                    end
                end
                LOCK_RB: if (rb_valid) begin
                    g_rb = 1'b1;
                    if (rb_end) state_nxt = IDLE;
                end
                // replay_active is ignored here so an NT packet is never cut.
                LOCK_NT: if (nt_valid) begin
                    g_nt = 1'b1;
                    if (nt_end) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign rb_ready     = g_rb;
    assign nt_ready     = g_nt;
    assign dllp_ready   = g_dllp;
    assign starve_event = g_promote;
    assign busy         = (state != IDLE) || tx_out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Counts TLP packets sent past a waiting non-urgent DLLP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!dllp_valid || g_dllp) begin
            starve_cnt <= '0;
        end else if (((g_rb && rb_end) || (g_nt && nt_end)) && !dllp_urgent &&
                     (starve_cnt != STARVE_CNT_W'(STARVE_LIMIT))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Output register: loads on transfer, holds while the PHY stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_out       <= '0;
            tx_out_valid <= 1'b0;
            tx_type      <= 1'b0;
            tx_out_end   <= 1'b0;
            tx_out_len   <= '0;
            tx_src       <= 2'd0;
        end else if (out_free) begin
            tx_out_valid <= g_rb || g_nt || g_dllp;
            if (g_rb) begin
                tx_out     <= rb_data;
                tx_type    <= 1'b1;
                tx_out_end <= rb_end;
                tx_out_len <= rb_len;
                tx_src     <= 2'd0;
            end else if (g_nt) begin
                tx_out     <= nt_data;
                tx_type    <= 1'b1;
                tx_out_end <= nt_end;
                tx_out_len <= nt_len;
                tx_src     <= 2'd1;
            end else if (g_dllp) begin
                tx_out     <= dllp_beat;
                tx_type    <= 1'b0;
                tx_out_end <= 1'b1;
                tx_out_len <= LEN_W'(2);
                tx_src     <= 2'd2;
            end
        end
    end

endmodule

// File: tb/tb_dl_tx_arbiter_gen2.sv
// Table-driven bench for dl_tx_arbiter_gen2: each record is one cycle of
// inputs, the expected combinational readies for that cycle and the expected
// registered outputs after the clock edge.
module tb_dl_tx_arbiter_gen2;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] rb_data, nt_data;
    logic         rb_valid, rb_end, nt_valid, nt_end;
    logic [5:0]   rb_len, nt_len;
    logic         rb_ready, nt_ready;
    logic [31:0]  dllp_data;
    logic [15:0]  dllp_crc;
    logic         dllp_valid, dllp_urgent, dllp_ready;
    logic         replay_active, tx_ready;
    logic [127:0] tx_out;
    logic         tx_out_valid, tx_type, tx_out_end;
    logic [5:0]   tx_out_len;
    logic [1:0]   tx_src;
    logic         starve_event, busy;

    always #5 clk = ~clk;

    dl_tx_arbiter_gen2 #(.DATA_W(128), .LEN_W(6), .STARVE_LIMIT(4), .STARVE_CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .rb_data(rb_data), .rb_valid(rb_valid), .rb_end(rb_end), .rb_len(rb_len), .rb_ready(rb_ready),
        .nt_data(nt_data), .nt_valid(nt_valid), .nt_end(nt_end), .nt_len(nt_len), .nt_ready(nt_ready),
        .dllp_data(dllp_data), .dllp_crc(dllp_crc), .dllp_valid(dllp_valid),
        .dllp_urgent(dllp_urgent), .dllp_ready(dllp_ready),
        .replay_active(replay_active), .tx_ready(tx_ready),
        .tx_out(tx_out), .tx_out_valid(tx_out_valid), .tx_type(tx_type), .tx_out_end(tx_out_end),
        .tx_out_len(tx_out_len), .tx_src(tx_src), .starve_event(starve_event), .busy(busy)
    );

    typedef struct packed {
        logic rbv, rbe; logic [5:0] rbl;
        logic ntv, nte; logic [5:0] ntl;
        logic dv, du, ra, txr;
        logic [31:0] tag;
        logic e_rr, e_nr, e_dr, e_se;
        logic e_v; logic [1:0] e_src; logic e_end; logic [5:0] e_len; logic e_busy;
    } vec_t;

    vec_t         tbl[$];
    int           nvec = 0;
    int           nerr = 0;
    logic [127:0] exp_data = '0;
    localparam logic [127:0] DLLP_BEAT = {32'hAABBCCDD, 16'h1234, 80'h0};

    function automatic vec_t mk(logic rbv, logic rbe, logic [5:0] rbl,
                                logic ntv, logic nte, logic [5:0] ntl,
                                logic dv, logic du, logic ra, logic txr,
                                logic rr, logic nr, logic dr, logic se,
                                logic ev, logic [1:0] src, logic en, logic [5:0] len, logic bz);
        vec_t v;
        v.rbv = rbv; v.rbe = rbe; v.rbl = rbl;
        v.ntv = ntv; v.nte = nte; v.ntl = ntl;
        v.dv = dv; v.du = du; v.ra = ra; v.txr = txr;
        v.tag = 32'h0;
        v.e_rr = rr; v.e_nr = nr; v.e_dr = dr; v.e_se = se;
        v.e_v = ev; v.e_src = src; v.e_end = en; v.e_len = len; v.e_busy = bz;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one vector, check readies before the edge and outputs after it.
    task automatic step(input vec_t v, input int idx);
        rb_valid = v.rbv; rb_end = v.rbe; rb_len = v.rbl; rb_data = {4{v.tag}};
        nt_valid = v.ntv; nt_end = v.nte; nt_len = v.ntl; nt_data = {4{v.tag ^ 32'hFFFF0000}};
        dllp_valid = v.dv; dllp_urgent = v.du; replay_active = v.ra; tx_ready = v.txr;
        #1;
        chk("rb_ready", idx, rb_ready, v.e_rr);
        chk("nt_ready", idx, nt_ready, v.e_nr);
        chk("dllp_ready", idx, dllp_ready, v.e_dr);
        chk("starve_event", idx, starve_event, v.e_se);
        if (v.e_rr)      exp_data = rb_data;
        else if (v.e_nr) exp_data = nt_data;
        else if (v.e_dr) exp_data = DLLP_BEAT;
        @(posedge clk); #1;
        chk("tx_out_valid", idx, tx_out_valid, v.e_v);
        chk("busy", idx, busy, v.e_busy);
        if (v.e_v) begin
            chk("tx_src", idx, tx_src, v.e_src);
            chk("tx_type", idx, tx_type, v.e_src != 2'd2);
            chk("tx_out_end", idx, tx_out_end, v.e_end);
            chk("tx_out_len", idx, tx_out_len, v.e_len);
            chk("tx_out", idx, tx_out, exp_data);
        end
        nvec++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vec_t idl;
        idl = mk(0,0,0, 0,0,0, 0,0,0,1, 0,0,0,0, 0,0,0,0,0);

        // RB 3-beat packet
        tbl.push_back(mk(1,0,4, 0,0,0, 0,0,0,1, 1,0,0,0, 1,0,0,4,1));
        tbl.push_back(mk(1,0,4, 0,0,0, 0,0,0,1, 1,0,0,0, 1,0,0,4,1));
        tbl.push_back(mk(1,1,2, 0,0,0, 0,0,0,1, 1,0,0,0, 1,0,1,2,1));
        tbl.push_back(idl);
        // replay_active blocks NT, RB wins
        tbl.push_back(mk(1,1,1, 1,1,3, 0,0,1,1, 1,0,0,0, 1,0,1,1,1));
        tbl.push_back(mk(0,0,0, 1,1,3, 0,0,1,1, 0,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0, 1,1,3, 0,0,0,1, 0,1,0,0, 1,1,1,3,1));
        tbl.push_back(idl);
        // NT 4-beat, urgent DLLP from beat 2, replay_active pulse mid-packet
        tbl.push_back(mk(0,0,0, 1,0,8, 0,0,0,1, 0,1,0,0, 1,1,0,8,1));
        tbl.push_back(mk(0,0,0, 1,0,8, 1,1,0,1, 0,1,0,0, 1,1,0,8,1));
        tbl.push_back(mk(0,0,0, 1,0,8, 1,1,1,1, 0,1,0,0, 1,1,0,8,1));
        tbl.push_back(mk(0,0,0, 1,1,5, 1,1,0,1, 0,1,0,0, 1,1,1,5,1));
        tbl.push_back(mk(0,0,0, 0,0,0, 1,1,0,1, 0,0,1,0, 1,2,1,2,1));
        tbl.push_back(idl);
        // tx_ready low for 3 cycles mid-packet
        tbl.push_back(mk(1,0,4, 0,0,0, 0,0,0,1, 1,0,0,0, 1,0,0,4,1));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(1,0,3, 0,0,0, 0,0,0,0, 0,0,0,0, 1,0,0,4,1));
        tbl.push_back(mk(1,0,3, 0,0,0, 0,0,0,1, 1,0,0,0, 1,0,0,3,1));
        tbl.push_back(mk(1,1,2, 0,0,0, 0,0,0,1, 1,0,0,0, 1,0,1,2,1));
        tbl.push_back(idl);
        // NT valid drops mid-packet: bubble, lock held against RB and urgent DLLP
        tbl.push_back(mk(0,0,0, 1,0,1, 0,0,0,1, 0,1,0,0, 1,1,0,1,1));
        tbl.push_back(mk(1,1,1, 0,0,0, 1,1,0,1, 0,0,0,0, 0,0,0,0,1));
        tbl.push_back(mk(1,1,1, 1,1,2, 0,0,0,1, 0,1,0,0, 1,1,1,2,1));
        tbl.push_back(mk(1,1,1, 0,0,0, 1,1,0,1, 0,0,1,0, 1,2,1,2,1));
        tbl.push_back(mk(1,1,1, 0,0,0, 0,0,0,1, 1,0,0,0, 1,0,1,1,1));
        tbl.push_back(idl);
        // starvation: 4 TLPs, promoted DLLP, remaining 2 TLPs
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1,1,1, 0,0,0, 1,0,0,1, 1,0,0,0, 1,0,1,1,1));
        tbl.push_back(mk(1,1,1, 0,0,0, 1,0,0,1, 0,0,1,1, 1,2,1,2,1));
        for (int k = 0; k < 2; k++)
            tbl.push_back(mk(1,1,1, 0,0,0, 0,0,0,1, 1,0,0,0, 1,0,1,1,1));
        tbl.push_back(idl);
        // lone non-urgent DLLP; non-urgent DLLP beats blocked NT
        tbl.push_back(mk(0,0,0, 0,0,0, 1,0,0,1, 0,0,1,0, 1,2,1,2,1));
        tbl.push_back(idl);
        tbl.push_back(mk(0,0,0, 1,1,3, 1,0,1,1, 0,0,1,0, 1,2,1,2,1));
        tbl.push_back(idl);

        // Reset state, with sources requesting while reset is held
        rst = 1'b1;
        rb_valid = 1'b1; rb_end = 1'b1; rb_len = 6'd1; rb_data = '1;
        nt_valid = 1'b1; nt_end = 1'b1; nt_len = 6'd1; nt_data = '1;
        dllp_data = 32'hAABBCCDD; dllp_crc = 16'h1234;
        dllp_valid = 1'b1; dllp_urgent = 1'b1; replay_active = 1'b0; tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst rb_ready", -1, rb_ready, 1'b0);
        chk("rst nt_ready", -1, nt_ready, 1'b0);
        chk("rst dllp_ready", -1, dllp_ready, 1'b0);
        chk("rst tx_out_valid", -1, tx_out_valid, 1'b0);
        chk("rst tx_out", -1, tx_out, 128'h0);
        chk("rst tx_type", -1, tx_type, 1'b0);
        chk("rst tx_out_end", -1, tx_out_end, 1'b0);
        chk("rst tx_out_len", -1, tx_out_len, 6'd0);
        chk("rst tx_src", -1, tx_src, 2'd0);
        chk("rst starve_event", -1, starve_event, 1'b0);
        chk("rst busy", -1, busy, 1'b0);
        nvec++;
        rst = 1'b0;
        rb_valid = 1'b0; nt_valid = 1'b0; dllp_valid = 1'b0; dllp_urgent = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            v.tag = 32'hC0DE0000 + i;
            step(v, i);
        end

        // Reset on beat 2 of a 4-beat RB packet
        v = mk(1,0,4, 0,0,0, 0,0,0,1, 1,0,0,0, 1,0,0,4,1);
        v.tag = 32'h5EED0001;
        step(v, 100);
        rb_valid = 1'b1; rb_end = 1'b0; rb_len = 6'd4;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst tx_out_valid", 101, tx_out_valid, 1'b0);
        chk("midrst busy", 101, busy, 1'b0);
        chk("midrst rb_ready", 101, rb_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("postrst tx_out_valid", 102, tx_out_valid, 1'b0);
        chk("postrst busy", 102, busy, 1'b0);
        nvec++;
        // FSM must be back in IDLE: an NT packet is granted, RB lock is gone
        v = mk(0,0,0, 1,1,7, 0,0,0,1, 0,1,0,0, 1,1,1,7,1);
        v.tag = 32'h5EED0002;
        step(v, 103);
        v = idl; v.tag = 32'h5EED0003;
        step(v, 104);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
